// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer
// Drains DATA_WIDTH-bit words from a synchronous FIFO with a one-cycle
// registered read port and emits them as OUT_WIDTH-bit beats on a
// valid/ready stream, with m_last marking the final beat of each word.
module fifo_rd_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;

  logic [DATA_WIDTH-1:0] shreg_shifted;
  logic                  rd_issue;

  // Output slice and post-handshake shift direction are fixed by MSB_FIRST.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign m_data        = shreg_q[DATA_WIDTH-1 -: OUT_WIDTH];
      assign shreg_shifted = shreg_q << OUT_WIDTH;
    end else begin : g_lsb_first
      assign m_data        = shreg_q[OUT_WIDTH-1:0];
      assign shreg_shifted = shreg_q >> OUT_WIDTH;
    end
  endgenerate

  // Reads may only be issued when enabled and the FIFO has data; held off
  // during reset so a FIFO still running is not popped into a discarded word.
  assign rd_issue = en & ~fifo_empty & rst_n;

  assign busy = (state_q != IDLE);

  // State, beat counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Next-state logic, read strobe and stream control.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    shreg_d    = shreg_q;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    m_last     = 1'b0;

    unique case (state_q)
      IDLE: begin
        fifo_rd_en = rd_issue;
        if (rd_issue) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        // FIFO data_out was updated on the edge that sampled fifo_rd_en.
        shreg_d    = fifo_data;
        beat_cnt_d = '0;
        state_d    = SEND;
      end

      SEND: begin
        m_valid = 1'b1;
        m_last  = (beat_cnt_q == LAST_CNT);
        if (m_ready) begin
          shreg_d    = shreg_shifted;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == LAST_CNT) begin
            // Issue the next read in the last-beat cycle so only one
            // FETCH bubble separates back-to-back words.
            fifo_rd_en = rd_issue;
            state_d    = rd_issue ? FETCH : IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Directed bench for fifo_rd_serializer: two instances (MSB-first and
// LSB-first) share a small FIFO model with a one-cycle registered read.
module tb_fifo_rd_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic        m_ready;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;
  logic        rd_a, rd_b;
  logic        va, vb;
  logic [7:0]  da, db;
  logic        la, lb;
  logic        ba, bb;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] fifo_mem [16];
  int          wr_ptr    = 0;
  int          rd_ptr    = 0;
  int          rd_pulses = 0;

  always #5 clk = ~clk;

  fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_a), .fifo_data(fifo_data), .m_valid(va),
    .m_ready(m_ready), .m_data(da), .m_last(la), .busy(ba)
  );

  fifo_rd_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_b), .fifo_data(fifo_data), .m_valid(vb),
    .m_ready(m_ready), .m_data(db), .m_last(lb), .busy(bb)
  );

  // FIFO model: registered read port, data valid the cycle after rd_en.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_a | rd_b) begin
      fifo_data <= fifo_mem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 1;
      rd_pulses <= rd_pulses + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; m_ready = 1'b1;
    cyc(); cyc();
    total_cnt++;
    if ({rd_a, va, la, ba, da} !== 12'h000 || {rd_b, vb, lb, bb, db} !== 12'h000)
      $display("FAIL reset_outputs a=%b_%b_%b_%b_%h b=%b_%b_%b_%b_%h required all 0",
               rd_a, va, la, ba, da, rd_b, vb, lb, bb, db);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (ba !== 1'b0 || rd_a !== 1'b0)
      $display("FAIL reset_idle busy=%b rd=%b required 0 0", ba, rd_a);
    else pass_cnt++;
  endtask

  task automatic test_msb_first();
    logic [31:0] w;
    int          p0;
    w  = 32'hA1B2C3D4;
    p0 = rd_pulses;
    push(w);
    en_a = 1'b1; m_ready = 1'b1;
    #1;
    total_cnt++;
    if (rd_a !== 1'b1) $display("FAIL msb_rd_issue rd=%b required 1", rd_a);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (va !== 1'b0 || ba !== 1'b1 || rd_a !== 1'b0)
      $display("FAIL msb_fetch valid=%b busy=%b rd=%b required 0 1 0", va, ba, rd_a);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++;
      if (va !== 1'b1 || da !== 8'(w >> (8 * (3 - i))) || la !== (i == 3) || rd_a !== 1'b0)
        $display("FAIL msb_beat%0d valid=%b data=%h last=%b rd=%b required 1 %h %b 0",
                 i, va, da, la, rd_a, 8'(w >> (8 * (3 - i))), (i == 3));
      else pass_cnt++;
    end
    cyc();
    total_cnt++;
    if (va !== 1'b0 || ba !== 1'b0 || rd_pulses - p0 !== 1)
      $display("FAIL msb_done valid=%b busy=%b pulses=%0d required 0 0 1",
               va, ba, rd_pulses - p0);
    else pass_cnt++;
    en_a = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [31:0] w;
    w = 32'hA1B2C3D4;
    push(w);
    en_b = 1'b1; m_ready = 1'b1;
    #1;
    total_cnt++;
    if (rd_b !== 1'b1 || rd_a !== 1'b0)
      $display("FAIL lsb_rd_issue rd_b=%b rd_a=%b required 1 0", rd_b, rd_a);
    else pass_cnt++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++;
      if (vb !== 1'b1 || db !== 8'(w >> (8 * i)) || lb !== (i == 3))
        $display("FAIL lsb_beat%0d valid=%b data=%h last=%b required 1 %h %b",
                 i, vb, db, lb, 8'(w >> (8 * i)), (i == 3));
      else pass_cnt++;
    end
    cyc();
    total_cnt++;
    if (vb !== 1'b0 || bb !== 1'b0)
      $display("FAIL lsb_done valid=%b busy=%b required 0 0", vb, bb);
    else pass_cnt++;
    en_b = 1'b0;
  endtask

  task automatic test_backpressure();
    push(32'hA1B2C3D4);
    en_a = 1'b1; m_ready = 1'b1;
    cyc();                       // FETCH
    cyc();                       // A1
    total_cnt++;
    if (da !== 8'hA1 || va !== 1'b1) $display("FAIL bp_a1 data=%h valid=%b required a1 1", da, va);
    else pass_cnt++;
    cyc();                       // B2 presented
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++;
      if (va !== 1'b1 || da !== 8'hB2 || la !== 1'b0 || dut_a.beat_cnt_q !== 2'd1)
        $display("FAIL bp_hold%0d valid=%b data=%h last=%b cnt=%0d required 1 b2 0 1",
                 k, va, da, la, dut_a.beat_cnt_q);
      else pass_cnt++;
      cyc();
    end
    m_ready = 1'b1;
    #1;
    total_cnt++;
    if (va !== 1'b1 || da !== 8'hB2) $display("FAIL bp_release data=%h valid=%b required b2 1", da, va);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (da !== 8'hC3 || la !== 1'b0) $display("FAIL bp_c3 data=%h last=%b required c3 0", da, la);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (da !== 8'hD4 || la !== 1'b1) $display("FAIL bp_d4 data=%h last=%b required d4 1", da, la);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (ba !== 1'b0) $display("FAIL bp_idle busy=%b required 0", ba);
    else pass_cnt++;
    en_a = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [2];
    int          p0;
    w[0] = 32'h11223344;
    w[1] = 32'h55667788;
    p0   = rd_pulses;
    push(w[0]); push(w[1]);
    en_a = 1'b1; m_ready = 1'b1;
    cyc();                       // FETCH word 0
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) begin
        cyc();
        total_cnt++;
        if (va !== 1'b1 || da !== 8'(w[j] >> (8 * (3 - i))) || la !== (i == 3) ||
            rd_a !== (j == 0 && i == 3))
          $display("FAIL b2b_w%0d_beat%0d valid=%b data=%h last=%b rd=%b required 1 %h %b %b",
                   j, i, va, da, la, rd_a, 8'(w[j] >> (8 * (3 - i))), (i == 3),
                   (j == 0 && i == 3));
        else pass_cnt++;
      end
      if (j == 0) begin
        cyc();                   // single bubble
        total_cnt++;
        if (va !== 1'b0 || ba !== 1'b1)
          $display("FAIL b2b_bubble valid=%b busy=%b required 0 1", va, ba);
        else pass_cnt++;
      end
    end
    cyc();
    total_cnt++;
    if (ba !== 1'b0 || rd_pulses - p0 !== 2)
      $display("FAIL b2b_done busy=%b pulses=%0d required 0 2", ba, rd_pulses - p0);
    else pass_cnt++;
    en_a = 1'b0;
  endtask

  task automatic test_empty_and_disable();
    int p0;
    p0 = rd_pulses;
    en_a = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      total_cnt++;
      if (rd_a !== 1'b0 || va !== 1'b0 || ba !== 1'b0 || fifo_empty !== 1'b1)
        $display("FAIL empty_c%0d rd=%b valid=%b busy=%b required 0 0 0", k, rd_a, va, ba);
      else pass_cnt++;
    end
    en_a = 1'b0;
    push(32'hA1B2C3D4);
    for (int k = 0; k < 5; k++) begin
      cyc();
      total_cnt++;
      if (rd_a !== 1'b0 || rd_b !== 1'b0 || ba !== 1'b0)
        $display("FAIL disabled_c%0d rd=%b busy=%b required 0 0", k, rd_a, ba);
      else pass_cnt++;
    end
    total_cnt++;
    if (rd_pulses - p0 !== 0) $display("FAIL empty_pulses got=%0d required 0", rd_pulses - p0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w;
    w = 32'hCAFEF00D;
    push(w);                     // A1B2C3D4 already queued ahead of it
    en_a = 1'b1; m_ready = 1'b1;
    cyc();                       // FETCH
    cyc();                       // A1
    cyc();                       // B2
    total_cnt++;
    if (da !== 8'hB2) $display("FAIL rst_pre data=%h required b2", da);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({rd_a, va, la, ba, da} !== 12'h000)
      $display("FAIL rst_async rd=%b valid=%b last=%b busy=%b data=%h required all 0",
               rd_a, va, la, ba, da);
    else pass_cnt++;
    cyc();
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (rd_a !== 1'b1) $display("FAIL rst_reissue rd=%b required 1", rd_a);
    else pass_cnt++;
    cyc();                       // FETCH
    for (int i = 0; i < 4; i++) begin
      cyc();
      total_cnt++;
      if (va !== 1'b1 || da !== 8'(w >> (8 * (3 - i))) || la !== (i == 3))
        $display("FAIL rst_next_beat%0d valid=%b data=%h last=%b required 1 %h %b",
                 i, va, da, la, 8'(w >> (8 * (3 - i))), (i == 3));
      else pass_cnt++;
    end
    cyc();
    en_a = 1'b0;
  endtask

  task automatic test_en_drop_mid_word();
    logic [31:0] w;
    int          p0;
    w  = 32'hA1B2C3D4;
    p0 = rd_pulses;
    push(w); push(32'h12345678);
    en_a = 1'b1; m_ready = 1'b1;
    cyc();                       // FETCH
    cyc();                       // A1
    total_cnt++;
    if (da !== 8'hA1) $display("FAIL endrop_a1 data=%h required a1", da);
    else pass_cnt++;
    en_a = 1'b0;
    for (int i = 1; i < 4; i++) begin
      cyc();
      total_cnt++;
      if (va !== 1'b1 || da !== 8'(w >> (8 * (3 - i))) || la !== (i == 3) || rd_a !== 1'b0)
        $display("FAIL endrop_beat%0d valid=%b data=%h last=%b rd=%b required 1 %h %b 0",
                 i, va, da, la, rd_a, 8'(w >> (8 * (3 - i))), (i == 3));
      else pass_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      total_cnt++;
      if (rd_a !== 1'b0 || ba !== 1'b0)
        $display("FAIL endrop_idle%0d rd=%b busy=%b required 0 0", k, rd_a, ba);
      else pass_cnt++;
    end
    total_cnt++;
    if (rd_pulses - p0 !== 1) $display("FAIL endrop_pulses got=%0d required 1", rd_pulses - p0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_back_to_back();
    test_empty_and_disable();
    test_reset_mid_word();
    test_en_drop_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_rd_serializer.md
Name: fifo_rd_serializer

Overview:
Downstream drain stage for the team's synchronous FIFO. Pops DATA_WIDTH-bit words through the FIFO read port and serializes each word into OUT_WIDTH-bit beats on a valid/ready stream. Accounts for the FIFO's one-cycle registered read latency: data_out is updated on the clock edge that samples rd_en. Sits between the FIFO and a narrow consumer, e.g. a byte-wide link or UART TX.

Parameters:
DATA_WIDTH, 32, FIFO word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 8, output beat width.
MSB_FIRST, 1, 1 = most-significant slice sent first; 0 = least-significant slice first.
(derived) BEATS = DATA_WIDTH/OUT_WIDTH, must be >= 2. CNT_W = $clog2(BEATS).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  enables new FIFO reads; a word already in progress always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO read strobe; combinational, one cycle per word.
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after fifo_rd_en.
m_valid  output  1  output beat valid.
m_ready  input  1  consumer ready.
m_data  output  OUT_WIDTH  output beat.
m_last  output  1  high with the final beat of each word.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, beat_cnt=0, shift register=0. Outputs m_valid=0, m_last=0, m_data=0, fifo_rd_en=0, busy=0. A word in progress is discarded.
- FSM has three states: IDLE, FETCH, SEND.
- IDLE:
  - fifo_rd_en = en & ~fifo_empty.
  - If fifo_rd_en is high, go to FETCH; otherwise stay in IDLE.
- FETCH (exactly 1 cycle):
  - Load shift register <= fifo_data; beat_cnt <= 0.
  - Go to SEND. m_valid=0 in this state.
- SEND:
  - m_valid=1.
  - m_data = shreg[DATA_WIDTH-1 -: OUT_WIDTH] if MSB_FIRST, else shreg[OUT_WIDTH-1:0].
  - m_last = (beat_cnt == BEATS-1).
- Handshake in SEND (m_valid & m_ready):
  - Shift shreg by OUT_WIDTH: left if MSB_FIRST, right otherwise; zero fill.
  - beat_cnt increments.
- While m_valid=1 and m_ready=0: m_data, m_last and beat_cnt hold stable. m_valid never drops before the handshake completes.
- Last beat accepted (handshake with m_last=1):
  - fifo_rd_en = en & ~fifo_empty in that same cycle.
  - If asserted, go to FETCH (back-to-back words); otherwise go to IDLE.
- fifo_rd_en is 0 in all other cycles. It is never asserted while fifo_empty=1, so the block never pops an empty FIFO.
- Throughput: BEATS beats per BEATS+1 cycles with m_ready tied high (one FETCH bubble per word).
- Latency: fifo_rd_en in cycle T gives first m_valid in cycle T+2.
- en deasserted mid-word: the remaining beats are still sent; no further read is issued.
- fifo_empty is ignored outside the read-issue cycles.
- m_ready is ignored when m_valid=0.

Test Plan:
1. DATA_WIDTH=32, OUT_WIDTH=8, MSB_FIRST=1; FIFO holds 0xA1B2C3D4; en=1, m_ready=1 -> one fifo_rd_en pulse; beats A1,B2,C3,D4 on consecutive cycles starting 2 cycles after rd_en; m_last only on D4; then IDLE, busy=0.
2. Same word, MSB_FIRST=0 -> beats D4,C3,B2,A1; m_last on A1.
3. Backpressure: m_ready=0 for 3 cycles while B2 is presented -> m_data holds B2, m_valid holds 1, beat_cnt unchanged; resumes C3,D4 once m_ready=1.
4. FIFO holds 0x11223344 then 0x55667788; m_ready=1 -> second rd_en in the same cycle as the 0x44 handshake; one bubble cycle; then 55,66,77,88; exactly 2 rd_en pulses total.
5. fifo_empty=1, en=1 for 20 cycles -> fifo_rd_en, m_valid and busy stay 0. Separately, with en=0 and fifo_empty=0 -> fifo_rd_en stays 0.
6. Reset/enable mid-word:
   - Assert rst_n=0 after beat B2 -> all outputs 0 immediately; after release, the block reads the next FIFO word cleanly.
   - Drop en after beat A1 -> B2,C3,D4 still sent, then no further rd_en.
